// File: rtl/nice_result_writer.sv
// Packs 5-bit class results three per word and writes them to consecutive ITCM addresses.
// Result-to-write latency is 2 cycles. Stalls hold the write; a word pushed into a full 2-entry FIFO is dropped and o_overflow is set.
module nice_result_writer #(
    parameter int              AW          = 16,
    parameter int              DW          = 16,
    parameter logic [AW-1:0]   BASE_ADDR   = 16'h0800,
    parameter int              MAX_RESULTS = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic          i_flush,
    input  logic [4:0]    i_result_data,
    input  logic          i_result_valid,
    output logic [AW-1:0] o_itcm_addr,
    output logic [DW-1:0] o_itcm_wdata,
    output logic          o_itcm_we,
    input  logic          i_itcm_ready,
    output logic          o_busy,
    output logic          o_done,
    output logic [7:0]    o_result_count,
    output logic          o_overflow
);
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH, S_DONE} state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_RESULTS);

    state_t        state;
    logic [14:0]   pack_q, pack_n;
    logic [1:0]    slot_q, slot_n;
    logic [7:0]    cnt_n;
    logic [DW-1:0] fifo_mem [2];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    fifo_cnt;
    logic          accept, flush_now, push, push_ok, pop;
    logic [DW-1:0] push_word;

    always_comb begin
        pack_n    = pack_q;
        slot_n    = slot_q;
        cnt_n     = o_result_count;
        push      = 1'b0;
        push_word = '0;
        accept    = (state == S_COLLECT) && i_result_valid && (o_result_count < MAX_CNT);
        if (accept) begin
            cnt_n = o_result_count + 8'd1;
            case (slot_q)
                2'd0:    pack_n[4:0]   = i_result_data;
                2'd1:    pack_n[9:5]   = i_result_data;
                default: pack_n[14:10] = i_result_data;
            endcase
            if (slot_q == 2'd2) begin
                push      = 1'b1;
                push_word = {1'b1, pack_n};
                pack_n    = '0;
                slot_n    = 2'd0;
            end else begin
                slot_n = slot_q + 2'd1;
            end
        end
        // The flush sees the word already updated by a same-cycle result.
        flush_now = (state == S_COLLECT) && (i_flush || (cnt_n == MAX_CNT));
        if (flush_now && (slot_n != 2'd0)) begin
            push      = 1'b1;
            push_word = {1'b0, pack_n};
            pack_n    = '0;
            slot_n    = 2'd0;
        end
        pop     = (fifo_cnt != 2'd0) && (!o_itcm_we || i_itcm_ready);
        push_ok = push && ((fifo_cnt != 2'd2) || pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            pack_q         <= '0;
            slot_q         <= '0;
            fifo_mem[0]    <= '0;
            fifo_mem[1]    <= '0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            fifo_cnt       <= '0;
            o_itcm_addr    <= BASE_ADDR;
            o_itcm_wdata   <= '0;
            o_itcm_we      <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_result_count <= '0;
            o_overflow     <= 1'b0;
        end else if (i_start) begin
            // Restart abandons any pending write and all buffered words.
            state          <= S_COLLECT;
            pack_q         <= '0;
            slot_q         <= '0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            fifo_cnt       <= '0;
            o_itcm_addr    <= BASE_ADDR;
            o_itcm_wdata   <= '0;
            o_itcm_we      <= 1'b0;
            o_busy         <= 1'b1;
            o_done         <= 1'b0;
            o_result_count <= '0;
            o_overflow     <= 1'b0;
        end else begin
            pack_q         <= pack_n;
            slot_q         <= slot_n;
            o_result_count <= cnt_n;
            if (push && !push_ok)
                o_overflow <= 1'b1;
            if (push_ok) begin
                fifo_mem[wr_ptr] <= push_word;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (o_itcm_we && i_itcm_ready)
                o_itcm_addr <= o_itcm_addr + 1'b1;
            if (pop) begin
                o_itcm_wdata <= fifo_mem[rd_ptr];
                o_itcm_we    <= 1'b1;
            end else if (o_itcm_we && i_itcm_ready) begin
                o_itcm_we <= 1'b0;
            end
            case (state)
                S_COLLECT: if (flush_now) state <= S_FLUSH;
                S_FLUSH: begin
                    if ((slot_q == 2'd0) && (fifo_cnt == 2'd0) && !o_itcm_we) begin
                        state  <= S_DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                end
                default: state <= state;
            endcase
        end
    end
endmodule

// File: tb/tb_nice_result_writer.sv
// Directed bench: a packing model fills a scoreboard of {addr, wdata} that a write monitor drains.
module tb_nice_result_writer;
    localparam int          AW   = 16;
    localparam int          DW   = 16;
    localparam int          MAXR = 12;
    localparam logic [15:0] BASE = 16'h0800;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start, i_flush, i_result_valid, i_itcm_ready;
    logic [4:0]    i_result_data;
    logic [AW-1:0] o_itcm_addr;
    logic [DW-1:0] o_itcm_wdata;
    logic          o_itcm_we, o_busy, o_done, o_overflow;
    logic [7:0]    o_result_count;

    nice_result_writer #(.AW(AW), .DW(DW), .BASE_ADDR(BASE), .MAX_RESULTS(MAXR)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_flush(i_flush),
        .i_result_data(i_result_data), .i_result_valid(i_result_valid),
        .o_itcm_addr(o_itcm_addr), .o_itcm_wdata(o_itcm_wdata), .o_itcm_we(o_itcm_we),
        .i_itcm_ready(i_itcm_ready), .o_busy(o_busy), .o_done(o_done),
        .o_result_count(o_result_count), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_writes = 0;
    int            w0;
    logic [31:0]   exp_q [$];
    logic [31:0]   wr_exp;
    logic [15:0]   last_wdata;
    logic [15:0]   hold_w;
    logic [15:0]   m_addr;
    logic [14:0]   m_pack;
    int            m_slot, m_cnt;
    bit            m_active;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void m_push(input logic [15:0] w);
        exp_q.push_back({m_addr, w});
        m_addr = m_addr + 16'd1;
    endfunction

    function automatic void m_flush();
        if (!m_active) return;
        if (m_slot != 0) m_push({1'b0, m_pack});
        m_pack   = '0;
        m_slot   = 0;
        m_active = 0;
    endfunction

    function automatic void m_result(input logic [4:0] r);
        if (!m_active || m_cnt >= MAXR) return;
        m_cnt++;
        m_pack[m_slot*5 +: 5] = r;
        if (m_slot == 2) begin
            m_push({1'b1, m_pack});
            m_pack = '0;
            m_slot = 0;
        end else begin
            m_slot++;
        end
        if (m_cnt == MAXR) m_flush();
    endfunction

    task automatic res(input logic [4:0] r, input bit fl = 1'b0);
        i_result_valid = 1'b1;
        i_result_data  = r;
        i_flush        = fl;
        m_result(r);
        if (fl) m_flush();
        tick();
        i_result_valid = 1'b0;
        i_flush        = 1'b0;
    endtask

    task automatic do_flush;
        i_flush = 1'b1;
        m_flush();
        tick();
        i_flush = 1'b0;
    endtask

    task automatic do_start;
        i_start = 1'b1;
        exp_q.delete();
        m_addr   = BASE;
        m_pack   = '0;
        m_slot   = 0;
        m_cnt    = 0;
        m_active = 1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 60 && !o_done; i++) tick();
        check(tag, o_done, 1);
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    // Write monitor: an unexpected write compares against X and therefore fails.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && o_itcm_we && i_itcm_ready) begin
            n_writes++;
            wr_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            check("itcm_write", {o_itcm_addr, o_itcm_wdata}, wr_exp);
            last_wdata = o_itcm_wdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_flush = 1'b0; i_result_valid = 1'b0;
        i_result_data = '0; i_itcm_ready = 1'b1;
        m_active = 0; m_addr = BASE; m_pack = '0; m_slot = 0; m_cnt = 0;
        #12;
        check("rst_addr", o_itcm_addr, BASE);
        check("rst_wdata", o_itcm_wdata, 0);
        check("rst_we", o_itcm_we, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_count", o_result_count, 0);
        check("rst_overflow", o_overflow, 0);
        #5 rst_n = 1'b1;
        tick();

        // Basic flow: one full word, write latency 2 cycles after the third result
        w0 = n_writes;
        do_start();
        check("busy_collect", o_busy, 1);
        res(5'd1); res(5'd2); res(5'd3);
        check("we_low_after_result", o_itcm_we, 0);
        do_flush();
        check("we_latency2", o_itcm_we, 1);
        check("wdata_basic", o_itcm_wdata, 16'h8C41);
        check("addr_basic", o_itcm_addr, BASE);
        wait_done("done_basic");
        check("count_basic", o_result_count, 3);
        check("busy_after_done", o_busy, 0);
        check("writes_basic", n_writes - w0, 1);

        // Partial word after one full word
        w0 = n_writes;
        do_start();
        res(5'd5); res(5'd5); res(5'd5); res(5'd9);
        do_flush();
        wait_done("done_partial");
        check("writes_partial", n_writes - w0, 2);
        check("last_partial", last_wdata, 16'h0009);

        // Backpressure: 12 results saturate into 4 words; one is held, two buffered, the fourth dropped
        i_itcm_ready = 1'b0;
        w0 = n_writes;
        do_start();
        for (int i = 1; i <= MAXR; i++) res(5'(i));
        tick(); tick();
        void'(exp_q.pop_back());
        m_addr = m_addr - 16'd1;
        check("ovf_set", o_overflow, 1);
        check("we_stalled", o_itcm_we, 1);
        check("addr_stalled", o_itcm_addr, BASE);
        hold_w = o_itcm_wdata;
        repeat (5) tick();
        check("wdata_stable", o_itcm_wdata, hold_w);
        check("wdata_first_word", hold_w, {1'b1, 5'd3, 5'd2, 5'd1});
        i_itcm_ready = 1'b1;
        wait_done("done_bp");
        check("writes_bp", n_writes - w0, 3);
        check("count_bp", o_result_count, MAXR);

        // Saturation: results past the limit ignored, automatic flush
        w0 = n_writes;
        do_start();
        for (int i = 0; i < MAXR + 2; i++) res(5'(17 + i));
        check("count_sat", o_result_count, MAXR);
        wait_done("done_sat");
        check("writes_sat", n_writes - w0, 4);

        // Restart mid-stall
        i_itcm_ready = 1'b0;
        do_start();
        for (int i = 1; i <= MAXR; i++) res(5'(i));
        tick();
        check("we_before_restart", o_itcm_we, 1);
        check("ovf_before_restart", o_overflow, 1);
        do_start();
        check("we_restart", o_itcm_we, 0);
        check("addr_restart", o_itcm_addr, BASE);
        check("count_restart", o_result_count, 0);
        check("ovf_restart", o_overflow, 0);
        check("done_restart", o_done, 0);
        i_itcm_ready = 1'b1;
        w0 = n_writes;
        res(5'd4); res(5'd5); res(5'd6);
        do_flush();
        wait_done("done_restart_run");
        check("writes_restart", n_writes - w0, 1);

        // Result together with flush: both results land in the partial word
        w0 = n_writes;
        do_start();
        res(5'd7);
        res(5'd8, 1'b1);
        wait_done("done_simul");
        check("writes_simul", n_writes - w0, 1);
        check("partial_both", last_wdata, 16'h0107);

        // Start together with a result: start wins
        i_result_valid = 1'b1;
        i_result_data  = 5'd3;
        do_start();
        i_result_valid = 1'b0;
        check("count_start_wins", o_result_count, 0);
        res(5'd3);
        check("count_after_one", o_result_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
